// File: rtl/light_timer_pkg.sv
// light_timer_pkg: shared definitions for the interval timer.
//   - state_e         : FSM encoding (RUN=0, ACK=1, DONE=2)
//   - DEF_*           : default timing parameters
//   - params_legal()  : parameter legality check used at elaboration
//   - prescale_width(): counter width for the prescaler (at least 1 bit)
package light_timer_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ACK  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_PRESCALE    = 1000;
  localparam int DEF_SHORT_TICKS = 5;
  localparam int DEF_LONG_TICKS  = 25;

  function automatic bit params_legal(input int prescale, input int short_ticks,
                                      input int long_ticks);
    return (prescale >= 1) && (short_ticks >= 1) && (long_ticks > short_ticks);
  endfunction

  // A prescale of 1 still needs a 1-bit register so the port widths stay legal.
  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/light_timer_tick.sv
// tick_gen: prescaler producing a one-cycle tick every PRESCALE enabled cycles.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset (counter to 0)
//   en   - count enable; counter holds when low
//   clr  - synchronous clear, wins over en
//   tick - high in the cycle where the count equals PRESCALE-1 and en is set
module tick_gen
  import light_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  // A clear on the same edge discards the tick so a restart never counts it.
  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/light_timer.sv
// light_timer: interval timer for the traffic-light controller handshake.
// A start-count request (sc) is acknowledged with a one-cycle fb pulse, after
// which the tick count restarts; ts/tl flag the short/long intervals.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-low reset; acts as an implicit start
//   sc      - start-count request (level, held until fb)
//   fb      - request acknowledge, one-cycle pulse
//   ts      - elapsed >= SHORT_TICKS
//   tl      - elapsed >= LONG_TICKS
//   elapsed - saturating tick count (debug)
module light_timer
  import light_timer_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int SHORT_TICKS = DEF_SHORT_TICKS,
  parameter int LONG_TICKS  = DEF_LONG_TICKS,
  parameter int CNT_W       = $clog2(LONG_TICKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sc,
  output logic             fb,
  output logic             ts,
  output logic             tl,
  output logic [CNT_W-1:0] elapsed
);

  if (!params_legal(PRESCALE, SHORT_TICKS, LONG_TICKS)) begin : g_param_check
    $error("light_timer: illegal PRESCALE/SHORT_TICKS/LONG_TICKS combination");
  end

  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] PRE_C   = CNT_W'(LONG_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic             accept;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  // A request in the ACK cycle is the one just acknowledged, so it is ignored.
  assign accept  = sc && (state_q != ST_ACK);
  assign pre_en  = (state_q == ST_RUN);
  assign pre_clr = accept || (state_q == ST_ACK);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (pre_en),
    .clr (pre_clr),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    if (accept) begin
      state_d   = ST_ACK;
      elapsed_d = '0;
    end else begin
      case (state_q)
        ST_ACK: begin
          state_d   = ST_RUN;
          elapsed_d = '0;
        end
        ST_RUN: begin
          if (tick) begin
            if (elapsed_q >= PRE_C) begin
              elapsed_d = LONG_C;
              state_d   = ST_DONE;
            end else begin
              elapsed_d = elapsed_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          elapsed_d = LONG_C;
        end
        default: begin
          state_d   = ST_RUN;
          elapsed_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
    end
  end

  // Pure decodes of registers: glitch-free, no path from sc.
  assign fb      = (state_q == ST_ACK);
  assign ts      = (elapsed_q >= SHORT_C);
  assign tl      = (elapsed_q >= LONG_C);
  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_light_timer.sv
// tb_light_timer: self-checking bench for light_timer.
// Two instances share clk and rst: dut (PRESCALE=4, SHORT=2, LONG=5) and
// dut6 (PRESCALE=1, SHORT=1, LONG=2). Each edge, expected outputs for both
// are pushed to a scoreboard from the latency rules and popped #1 later.
module tb_light_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sc0 = 1'b0;
  logic       sc1 = 1'b0;
  logic       fb0, ts0, tl0;
  logic [2:0] el0;
  logic       fb1, ts1, tl1;
  logic [1:0] el1;

  light_timer #(
    .PRESCALE(4), .SHORT_TICKS(2), .LONG_TICKS(5)
  ) dut (
    .clk(clk), .rst(rst), .sc(sc0), .fb(fb0), .ts(ts0), .tl(tl0), .elapsed(el0)
  );

  light_timer #(
    .PRESCALE(1), .SHORT_TICKS(1), .LONG_TICKS(2)
  ) dut6 (
    .clk(clk), .rst(rst), .sc(sc1), .fb(fb1), .ts(ts1), .tl(tl1), .elapsed(el1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int pr[2] = '{4, 1};
  int sh[2] = '{2, 1};
  int lg[2] = '{5, 2};

  // r_edge: first counting edge of the current run; acc_edge: last accept edge.
  int r_edge[2]   = '{0, 0};
  int acc_edge[2] = '{-100, -100};
  int last_el[2]  = '{0, 0};

  typedef struct {
    int   d;
    int   n;
    logic fb;
    logic ts;
    logic tl;
    int   el;
  } exp_t;

  exp_t sb[$];

  task automatic step(input string tname, input logic s0, input logic s1);
    logic        scv[2];
    exp_t        e;
    logic        afb, ats, atl;
    logic [31:0] ael;
    sc0 = s0;
    sc1 = s1;
    scv[0] = s0;
    scv[1] = s1;
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      e.d  = d;
      e.n  = cyc;
      e.fb = 1'b0;
      e.el = 0;
      if (!rst) begin
        r_edge[d]   = cyc + 1;
        acc_edge[d] = -100;
      end else if (acc_edge[d] == cyc - 1) begin
        // ACK cycle: request ignored, counters held at 0
      end else if (scv[d]) begin
        acc_edge[d] = cyc;
        r_edge[d]   = cyc + 2;
        e.fb        = 1'b1;
        $display("tx: %s dut%0d request accepted at edge %0d", tname, d, cyc);
      end else begin
        e.el = (cyc - r_edge[d] + 1) / pr[d];
        if (e.el > lg[d]) e.el = lg[d];
      end
      e.ts = (e.el >= sh[d]);
      e.tl = (e.el >= lg[d]);
      last_el[d] = e.el;
      sb.push_back(e);
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        afb = fb0; ats = ts0; atl = tl0; ael = {29'd0, el0};
      end else begin
        afb = fb1; ats = ts1; atl = tl1; ael = {30'd0, el1};
      end
      checks++;
      if (afb !== e.fb || ats !== e.ts || atl !== e.tl || ael !== e.el) begin
        errors++;
        $display("FAIL %s dut%0d edge %0d: fb/ts/tl/elapsed got %0b/%0b/%0b/%0d want %0b/%0b/%0b/%0d",
                 tname, e.d, e.n, afb, ats, atl, ael, e.fb, e.ts, e.tl, e.el);
      end
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tname);
    checks++;
    if ({fb0, ts0, tl0, el0} !== 6'd0) begin
      errors++;
      $display("FAIL %s dut0: fb/ts/tl/elapsed got %0b/%0b/%0b/%0d want 0/0/0/0",
               tname, fb0, ts0, tl0, el0);
    end
    checks++;
    if ({fb1, ts1, tl1, el1} !== 5'd0) begin
      errors++;
      $display("FAIL %s dut6: fb/ts/tl/elapsed got %0b/%0b/%0b/%0d want 0/0/0/0",
               tname, fb1, ts1, tl1, el1);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1 check_zero("reset_async_no_clock");
    step("reset_hold", 1'b0, 1'b0);
    step("reset_hold_sc", 1'b1, 1'b1);
    rst = 1'b1;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 120; i++) step("free_run", 1'b0, 1'b0);
  endtask

  task automatic test_request_in_done();
    step("done_req", 1'b1, 1'b1);
    step("done_req_hold", 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step("done_req_run", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step("b2b_req", 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step("b2b_run", 1'b0, 1'b0);
  endtask

  task automatic test_mid_count_request();
    step("mid_first_req", 1'b1, 1'b0);
    for (int i = 0; i < 40 && last_el[0] != 3; i++) step("mid_wait", 1'b0, 1'b0);
    checks++;
    if (ts0 !== 1'b1 || el0 !== 3'd3) begin
      errors++;
      $display("FAIL mid_setup dut0: ts/elapsed got %0b/%0d want 1/3", ts0, el0);
    end
    step("mid_req", 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step("mid_run", 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step("ar_req", 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step("ar_pre", 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 check_zero("async_reset_mid_count");
    step("ar_hold", 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) step("ar_rerun", 1'b0, 1'b0);
    // reset landing in the ACK cycle drops the pending request
    step("ar_ack_req", 1'b1, 1'b1);
    #1 rst = 1'b0;
    #1 check_zero("async_reset_mid_ack");
    step("ar_ack_hold", 1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 22; i++) step("ar_ack_rerun", 1'b0, 1'b0);
  endtask

  task automatic test_min_params();
    step("min_req", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("min_run", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("min_b2b", 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("min_b2b_run", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_request_in_done();
    test_back_to_back();
    test_mid_count_request();
    test_async_reset();
    test_min_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_timer.md
Name: light_timer

Overview:
- Interval timer serving the traffic-light controller's timing interface, on the other end of the sc/fb/ts/tl handshake.
- Accepts a start-count request (sc) and acknowledges it with a one-cycle fb pulse.
- After acknowledging, restarts an elapsed-time count and raises ts (short interval, yellow phase) and tl (long interval, green phase).
- Instantiated beside the light FSM in the traffic-light top level; runs from the same clk.

Parameters:
- PRESCALE, 1000: clk cycles per timer tick; must be >= 1.
- SHORT_TICKS, 5: ticks until ts asserts; must be >= 1.
- LONG_TICKS, 25: ticks until tl asserts; must be > SHORT_TICKS.
- CNT_W, $clog2(LONG_TICKS+1): width of the tick counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; logic is in reset while rst=0.
- sc  input  1  start-count request, level; held by the requester until fb is seen.
- fb  output  1  request acknowledge; one-cycle pulse.
- ts  output  1  short interval elapsed, level.
- tl  output  1  long interval elapsed, level.
- elapsed  output  CNT_W  current tick count, saturating; for debug.

Behaviour:
- Reset (rst=0): outputs go low immediately and asynchronously, with no clock needed: fb=0, ts=0, tl=0, elapsed=0. Prescale counter = 0. State = RUN.
- Reset therefore acts as an implicit start, so the light FSM's first tl arrives without an sc request.
- States:
  - ACK: fb=1; tick and prescale counters held at 0.
  - RUN: counting.
  - DONE: elapsed saturated at LONG_TICKS; prescaler stopped.
- Request acceptance: sc=1 sampled at a rising edge while state != ACK -> next state ACK.
  - Valid from RUN or DONE, including mid-count.
  - Tick counter and prescale counter clear on that edge.
- ACK lasts exactly one cycle, then RUN.
- sc is ignored while in ACK. sc still high in that cycle is the same request, so back-to-back requests need sc high again in the cycle after fb.
- Prescaler (RUN only): counts 0..PRESCALE-1 and wraps to 0. A tick fires in the cycle where the count = PRESCALE-1.
- On tick: elapsed increments. On the tick that reaches LONG_TICKS, next state is DONE.
- In DONE: elapsed holds LONG_TICKS and the prescaler holds 0.
- ts = (elapsed >= SHORT_TICKS); tl = (elapsed >= LONG_TICKS). Both are decodes of the registered count only, so they are glitch-free with no combinational path from sc.
- Latency from the accepting edge E:
  - fb high for the cycle after E.
  - ts and tl drop in the cycle after E.
  - ts rises after edge E+1+SHORT_TICKS*PRESCALE.
  - tl rises after edge E+1+LONG_TICKS*PRESCALE.
- After reset release (first edge R): ts rises after edge R-1+SHORT_TICKS*PRESCALE; tl follows the same rule with LONG_TICKS.
- Reset mid-count or mid-ACK: everything is reinitialised as above; any pending request is dropped.
- Asynchronous assert, synchronous behaviour after release. The first edge with rst=1 is the first counting edge.

Decomposition:
- Shared package light_timer_pkg:
  - State encoding localparams: ST_RUN=2'd0, ST_ACK=2'd1, ST_DONE=2'd2.
  - Parameter-legality constants/checks.
- One sub-module, tick_gen: prescaler with enable and synchronous clear that outputs a one-cycle tick.
- light_timer holds the FSM, the tick counter and the output decode.

Test Plan (PRESCALE=4, SHORT_TICKS=2, LONG_TICKS=5 unless noted):
1. Release reset, sc=0 -> fb never asserts; ts rises after the 8th edge and tl after the 20th; elapsed stops at 5 and holds for 100 more cycles.
2. In DONE, sc high for 2 cycles from edge E (requester style) -> exactly one fb pulse in cycle E+1; ts/tl low from E+1; ts rises after edge E+9, tl after edge E+21.
3. sc high for 3 consecutive edges -> fb pulses after the 1st edge, is low after the 2nd, and pulses again after the 3rd (second request accepted); counting restarts from the 3rd edge.
4. Request at elapsed=3 (ts high) -> ts drops the next cycle, elapsed=0, ts returns 9 edges after acceptance.
5. Drive rst=0 mid-count between clock edges -> fb/ts/tl/elapsed go to 0 with no clock edge; after release, the timing of scenario 1 repeats.
6. PRESCALE=1, SHORT_TICKS=1, LONG_TICKS=2 -> request at E: fb in cycle E+1, ts after E+2, tl after E+3; boundary wrap of tick_gen checked.
